// File: rtl/cksum_check.sv
// -----------------------------------------------------------------------------
// cksum_check
//
// Verifies a 16-bit ones-complement checksum (IPv4 style) over a field held in
// memory. On a start request the block walks the field one halfword per cycle,
// accumulates into a 32-bit sum, folds the carries back in twice and reports
// pass when the folded sum is all-ones.
//
// Optional feature (compile-time macro CKSUM_CHECK_ERRCNT_EN):
//   adds err_cnt_o, a saturating count of failed checks.
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous, active-low reset
//   start_i        verify request, level, held until ready_o is seen
//   field_start_i  byte address of the first halfword (checksum included)
//   field_len_i    covered field length in bytes
//   mem_ce_o       memory chip enable (high while halfwords are fetched)
//   mem_we_o       memory write enable, always 0
//   mem_addr_o     memory byte address
//   mem_width_o    access width in bytes (2 once a check has started)
//   mem_data_o     memory write data, always 0
//   mem_data_i     same-cycle read data, halfword in bits [15:0]
//   ready_o        result valid
//   pass_o         checksum correct, qualified by ready_o
//   err_cnt_o      failed-check counter (CKSUM_CHECK_ERRCNT_EN only)
//
// State table
//   state | meaning
//   FREE  | idle, waiting for start_i; last result still shown
//   SUM   | one halfword accumulated per cycle until addr reaches end_addr
//   FOLD  | second carry fold, result compare, ready_o raised
//   DONE  | result held until start_i drops
// -----------------------------------------------------------------------------

`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module cksum_check #(
    parameter int ERR_CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [`ADDR_BUS] field_start_i,
    input  logic [`DATA_BUS] field_len_i,
    output logic             mem_ce_o,
    output logic             mem_we_o,
    output logic [`ADDR_BUS] mem_addr_o,
    output logic [3:0]       mem_width_o,
    output logic [`DATA_BUS] mem_data_o,
    input  logic [`DATA_BUS] mem_data_i,
    output logic             ready_o,
    output logic             pass_o
`ifdef CKSUM_CHECK_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] SUM  = 2'd1;
    localparam logic [1:0] FOLD = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    if (ERR_CNT_W < 1) begin : g_err_cnt_w_invalid
        $error("cksum_check: ERR_CNT_W must be at least 1");
    end

    logic [1:0]       state;
    logic [`ADDR_BUS] addr;
    logic [`ADDR_BUS] end_addr;
    logic [31:0]      acc;
    logic             ce;
    logic [3:0]       width;
    logic             ready;
    logic             pass;

    // Upper halves of the acc summed; used for both folds. After the first
    // fold acc is at most 0x1FFFE, so the second fold cannot carry again.
    logic [16:0]      acc_fold;
    logic             fold_pass;
    logic             addr_below_end;

    // Only the low halfword of the read bus carries data.
    logic             unused_data_hi;

    assign acc_fold       = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
    assign fold_pass      = (acc_fold[15:0] == 16'hFFFF);
    assign addr_below_end = (addr < end_addr);
    assign unused_data_hi = ^mem_data_i[31:16];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FREE;
            addr     <= '0;
            end_addr <= '0;
            acc      <= '0;
            ce       <= 1'b0;
            width    <= 4'd0;
            ready    <= 1'b0;
            pass     <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (start_i) begin
                        // end_addr wraps modulo 2^32; a wrapped end lands below
                        // the start so SUM exits immediately with nothing summed.
                        end_addr <= field_start_i + field_len_i;
                        addr     <= field_start_i;
                        ce       <= 1'b1;
                        width    <= 4'd2;
                        acc      <= '0;
                        ready    <= 1'b0;
                        pass     <= 1'b0;
                        state    <= SUM;
                    end
                end
                SUM: begin
                    if (addr_below_end) begin
                        acc  <= acc + {16'h0, mem_data_i[15:0]};
                        addr <= addr + 32'd2;
                    end else begin
                        ce    <= 1'b0;
                        acc   <= {15'h0, acc_fold};
                        state <= FOLD;
                    end
                end
                FOLD: begin
                    pass  <= fold_pass;
                    ready <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    if (!start_i) begin
                        state <= FREE;
                    end
                end
                default: begin
                    state <= FREE;
                end
            endcase
        end
    end

`ifdef CKSUM_CHECK_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if ((state == FOLD) && !fold_pass && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign err_cnt_o = err_cnt;
`endif

    assign mem_ce_o    = ce;
    assign mem_we_o    = 1'b0;
    assign mem_addr_o  = addr;
    assign mem_width_o = width;
    assign mem_data_o  = '0;
    assign ready_o     = ready;
    assign pass_o      = pass;

endmodule

// File: tb/tb_cksum_check.sv
module tb_cksum_check;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] field_start_i;
    logic [31:0] field_len_i;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_width_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        ready_o;
    logic        pass_o;
`ifdef CKSUM_CHECK_ERRCNT_EN
    logic [15:0] err_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    logic [15:0] hw_mem [0:255];

    always #5 clk = ~clk;

    // Same-cycle memory; upper bits carry address-dependent junk the DUT must ignore.
    assign mem_data_i = {mem_addr_o[15:0] ^ 16'hA5C3, hw_mem[mem_addr_o[8:1]]};

    cksum_check dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .field_start_i (field_start_i),
        .field_len_i   (field_len_i),
        .mem_ce_o      (mem_ce_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_width_o   (mem_width_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .ready_o       (ready_o),
        .pass_o        (pass_o)
`ifdef CKSUM_CHECK_ERRCNT_EN
        ,
        .err_cnt_o     (err_cnt_o)
`endif
    );

    // ---------------- reference model ----------------
    function automatic int model_n(input logic [31:0] s, input logic [31:0] l);
        longint unsigned e;
        e = longint'(s) + longint'(l);
        if (e > 64'h0000_0000_FFFF_FFFF) return 0;
        return int'((longint'(l) + 1) / 2);
    endfunction

    function automatic logic [15:0] ones_sum(input logic [31:0] s, input int count);
        longint unsigned sum;
        logic [31:0] a;
        sum = 0;
        for (int i = 0; i < count; i++) begin
            a = s + 32'(2 * i);
            sum += hw_mem[a[8:1]];
        end
        while ((sum >> 16) != 0) sum = (sum & 64'hFFFF) + (sum >> 16);
        return sum[15:0];
    endfunction

    function automatic logic model_pass(input logic [31:0] s, input logic [31:0] l);
        return ones_sum(s, model_n(s, l)) == 16'hFFFF;
    endfunction

    // ---------------- one full check ----------------
    task automatic run_check(input logic [31:0] s, input logic [31:0] l,
                             input bit toggle, input string name);
        int n;
        logic exp_pass;
        int reads;
        int lat;
        bit trace_ok;
        bit bus_ok;
        logic [31:0] bad_addr;
        n        = model_n(s, l);
        exp_pass = model_pass(s, l);
        reads    = 0;
        lat      = -1;
        trace_ok = 1'b1;
        bus_ok   = 1'b1;
        bad_addr = '0;
        field_start_i = s;
        field_len_i   = l;
        start_i       = 1'b1;
        @(posedge clk); #1;
        field_start_i = $urandom;
        field_len_i   = $urandom;
        for (int c = 0; c < 400; c++) begin
            if (mem_we_o !== 1'b0 || mem_data_o !== 32'h0) bus_ok = 1'b0;
            if (ready_o === 1'b1) begin
                lat = c;
                break;
            end
            if (mem_ce_o === 1'b1) begin
                if (mem_addr_o !== s + 32'(2 * reads)) begin
                    trace_ok = 1'b0;
                    bad_addr = mem_addr_o;
                end
                reads++;
            end
            if (toggle) start_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        start_i = 1'b1;
        if (!exp_pass) exp_err++;

        checks++;
        if (lat !== n + 2) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, n + 2);
        end
        checks++;
        if (reads !== n + 1 || !trace_ok) begin
            errors++;
            $display("FAIL %s addr_trace got %0d ce cycles (bad addr %h) want %0d from %h step 2",
                     name, reads, bad_addr, n + 1, s);
        end
        checks++;
        if (pass_o !== exp_pass) begin
            errors++;
            $display("FAIL %s pass got %b want %b", name, pass_o, exp_pass);
        end
        checks++;
        if (!bus_ok || mem_width_o !== 4'd2) begin
            errors++;
            $display("FAIL %s bus got we/data ok=%b width=%0d want ok=1 width=2",
                     name, bus_ok, mem_width_o);
        end
`ifdef CKSUM_CHECK_ERRCNT_EN
        checks++;
        if (err_cnt_o !== 16'(exp_err)) begin
            errors++;
            $display("FAIL %s err_cnt got %0d want %0d", name, err_cnt_o, exp_err);
        end
`endif
        // DONE holds; dropping start returns to FREE but keeps the result shown.
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b1 || pass_o !== exp_pass || mem_ce_o !== 1'b0) begin
            errors++;
            $display("FAIL %s hold got ready=%b pass=%b ce=%b want ready=1 pass=%b ce=0",
                     name, ready_o, pass_o, mem_ce_o, exp_pass);
        end
    endtask

    task automatic load_ipv4(input logic [7:0] base_hw, input logic [15:0] cks);
        logic [15:0] hdr [0:9];
        hdr = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                16'hB861, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};
        hdr[5] = cks;
        for (int i = 0; i < 10; i++) hw_mem[base_hw + 8'(i)] = hdr[i];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        start_i = 1'b0;
        field_start_i = 32'h0;
        field_len_i = 32'h0;
        for (int i = 0; i < 256; i++) hw_mem[i] = 16'($urandom);
        #2;
        checks++;
        if ({ready_o, pass_o, mem_ce_o, mem_we_o} !== 4'b0 || mem_addr_o !== 32'h0 ||
            mem_width_o !== 4'h0 || mem_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b pass=%b ce=%b addr=%h width=%0d want all 0",
                     ready_o, pass_o, mem_ce_o, mem_addr_o, mem_width_o);
        end
`ifdef CKSUM_CHECK_ERRCNT_EN
        checks++;
        if (err_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_err_cnt got %0d want 0", err_cnt_o);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b0 || mem_ce_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b ce=%b want 0 0", ready_o, mem_ce_o);
        end
    endtask

    task automatic test_ipv4();
        load_ipv4(8'h10, 16'hB861);
        run_check(32'h20, 32'd20, 1'b0, "ipv4_good");
        checks++;
        if (pass_o !== 1'b1) begin
            errors++;
            $display("FAIL ipv4_good_vector pass got %b want 1", pass_o);
        end
        load_ipv4(8'h10, 16'hB862);
        run_check(32'h20, 32'd20, 1'b0, "ipv4_bad");
        checks++;
        if (pass_o !== 1'b0) begin
            errors++;
            $display("FAIL ipv4_bad_vector pass got %b want 0", pass_o);
        end
    endtask

    task automatic test_carry();
        hw_mem[8'h40] = 16'hFFFF;
        hw_mem[8'h41] = 16'hFFFF;
        run_check(32'h80, 32'd4, 1'b0, "carry_fold");
        checks++;
        if (pass_o !== 1'b1) begin
            errors++;
            $display("FAIL carry_fold_vector pass got %b want 1", pass_o);
        end
    endtask

    task automatic test_len0_and_wrap();
        run_check(32'h30, 32'd0, 1'b0, "len_zero");
        checks++;
        if (pass_o !== 1'b0) begin
            errors++;
            $display("FAIL len_zero_vector pass got %b want 0", pass_o);
        end
        run_check(32'hFFFF_FF00, 32'h200, 1'b0, "end_wrap");
    endtask

    task automatic test_odd();
        hw_mem[8'h30] = 16'h1234;
        hw_mem[8'h31] = 16'hEDCB;
        hw_mem[8'h32] = 16'h0000;
        run_check(32'h60, 32'd3, 1'b0, "odd_len3");
        run_check(32'h60, 32'd1, 1'b0, "odd_len1");
        run_check(32'h61, 32'd5, 1'b0, "odd_start");
    endtask

    task automatic test_start_toggle();
        load_ipv4(8'h50, 16'hB861);
        run_check(32'hA0, 32'd20, 1'b1, "start_toggle");
    endtask

    task automatic test_random();
        logic [31:0] s;
        logic [31:0] l;
        int n;
        for (int t = 0; t < 20; t++) begin
            s = 32'($urandom_range(0, 255)) * 2 + 32'($urandom_range(0, 1) & (t % 5 == 0 ? 1 : 0));
            l = 32'($urandom_range(0, 64));
            n = model_n(s, l);
            for (int i = 0; i < 40; i++) hw_mem[8'((s >> 1) + 32'(i))] = 16'($urandom);
            if (n > 0 && $urandom_range(0, 1) == 1) begin
                logic [31:0] a;
                a = s + 32'(2 * (n - 1));
                hw_mem[a[8:1]] = ~ones_sum(s, n - 1);
            end
            run_check(s, l, t[0], "random");
        end
    endtask

    task automatic test_reset_mid_sum();
        int c;
        logic exp_pass;
        load_ipv4(8'h10, 16'hB862);
        exp_pass = model_pass(32'h20, 32'd20);
        field_start_i = 32'h20;
        field_len_i   = 32'd20;
        start_i       = 1'b1;
        @(posedge clk); #1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b0;
        #1;
        exp_err = 0;
        checks++;
        if ({ready_o, pass_o, mem_ce_o} !== 3'b0 || mem_addr_o !== 32'h0 || mem_width_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_sum got rdy=%b pass=%b ce=%b addr=%h width=%0d want all 0",
                     ready_o, pass_o, mem_ce_o, mem_addr_o, mem_width_o);
        end
`ifdef CKSUM_CHECK_ERRCNT_EN
        checks++;
        if (err_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_sum_err_cnt got %0d want 0", err_cnt_o);
        end
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mem_ce_o !== 1'b1 || mem_addr_o !== 32'h20 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL first_accept got ce=%b addr=%h rdy=%b want ce=1 addr=00000020 rdy=0",
                     mem_ce_o, mem_addr_o, ready_o);
        end
        c = 0;
        while (ready_o !== 1'b1 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        if (!exp_pass) exp_err++;
        checks++;
        if (ready_o !== 1'b1 || pass_o !== exp_pass || c !== 12) begin
            errors++;
            $display("FAIL after_reset_check got rdy=%b pass=%b lat=%0d want rdy=1 pass=%b lat=12",
                     ready_o, pass_o, c, exp_pass);
        end
`ifdef CKSUM_CHECK_ERRCNT_EN
        checks++;
        if (err_cnt_o !== 16'(exp_err)) begin
            errors++;
            $display("FAIL after_reset_err_cnt got %0d want %0d", err_cnt_o, exp_err);
        end
`endif
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        load_ipv4(8'h10, 16'hB861);
        run_check(32'h20, 32'd20, 1'b0, "b2b_first");
        run_check(32'h20, 32'd20, 1'b0, "b2b_second");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ipv4();
        test_carry();
        test_len0_and_wrap();
        test_odd();
        test_start_toggle();
        test_back_to_back();
        test_random();
        test_reset_mid_sum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cksum_check.md
CKSUM_CHECK -- requirements
Module: cksum_check

Interface
REQ-001 Parameter: ERR_CNT_W, default 16, width of the fail counter; used only when CKSUM_CHECK_ERRCNT_EN is defined.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 start_i  input  1  verify request; level, held high until ready_o is observed.
REQ-005 field_start_i  input  `ADDR_BUS  byte address of the first halfword of the covered field, checksum included.
REQ-006 field_len_i  input  `DATA_BUS  covered field length in bytes.
REQ-007 mem_ce_o  output  1  memory chip enable.
REQ-008 mem_we_o  output  1  memory write enable; this block only reads.
REQ-009 mem_addr_o  output  `ADDR_BUS  memory byte address.
REQ-010 mem_width_o  output  4  access width in bytes.
REQ-011 mem_data_o  output  `DATA_BUS  memory write data; unused.
REQ-012 mem_data_i  input  `DATA_BUS  read data for the current mem_addr_o, same cycle; bits [15:0] carry the halfword.
REQ-013 ready_o  output  1  result valid.
REQ-014 pass_o  output  1  1 = field checksum correct; qualified by ready_o.
REQ-015 err_cnt_o  output  ERR_CNT_W  saturating count of failed checks; present only with CKSUM_CHECK_ERRCNT_EN.

Function
REQ-016 The FSM SHALL use states FREE, SUM, FOLD and DONE, with default->FREE.
REQ-017 FREE with start_i=1 SHALL latch end_addr = field_start_i + field_len_i, which is 32-bit and wraps.
REQ-018 On the same FREE acceptance edge the block SHALL set addr=field_start_i, mem_ce_o=1, mem_we_o=0, mem_width_o=2, acc=0, ready_o=0, pass_o=0, and move to SUM.
REQ-019 SUM with addr < end_addr SHALL perform acc += {16'h0, mem_data_i[15:0]} (32-bit accumulator) and addr += 2, once per cycle.
REQ-020 SUM with addr >= end_addr SHALL set mem_ce_o=0, acc = acc[31:16] + acc[15:0], and move to FOLD.
REQ-021 FOLD SHALL compute s = low 16 bits of acc[31:16] + acc[15:0], set pass_o = (s == 16'hFFFF), set ready_o=1, and move to DONE.
REQ-022 DONE SHALL hold ready_o and pass_o stable, and SHALL return to FREE when start_i=0.
REQ-023 ready_o and pass_o SHALL clear only when the next start is accepted.
REQ-024 Latency: with N = ceil(len/2) halfwords, ready_o SHALL rise N+2 cycles after the acceptance edge.
REQ-025 Odd field_len_i SHALL read ceil(len/2) halfwords, including the byte past the field.
REQ-026 field_len_i = 0 SHALL perform zero accumulations and give pass_o=0, with ready_o rising after 2 cycles.
REQ-027 If end_addr wraps below field_start_i, zero halfwords SHALL be summed, with the same result as REQ-026.
REQ-028 start_i SHALL be ignored in SUM and FOLD; field_* inputs SHALL be sampled only at acceptance.
REQ-029 mem_we_o SHALL stay 0 and mem_data_o SHALL stay 0 at all times.
REQ-030 mem_addr_o SHALL be combinationally equal to internal addr.

Reset
REQ-031 rst=0 SHALL immediately, independent of clk, force state=FREE, acc=0, addr=0, end_addr=0, and all outputs to 0, including err_cnt_o.
REQ-032 Reset asserted mid-SUM SHALL abort the check without producing a result; no err_cnt_o increment.
REQ-033 After rst returns to 1, the first acceptance SHALL occur on the first clk edge with start_i=1.

Configuration
REQ-034 With CKSUM_CHECK_ERRCNT_EN defined, FOLD with pass=0 SHALL increment err_cnt_o, saturating at all-ones.
REQ-035 Without CKSUM_CHECK_ERRCNT_EN, err_cnt_o and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-036 20-byte IPv4 header 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7, len=20 -> 10 reads at start, start+2, ..., start+18; ready_o at cycle 12; pass_o=1.
REQ-037 Same header with B861 replaced by B862 -> pass_o=0; err_cnt_o goes 0->1 (macro on).
REQ-038 Halfwords FFFF, FFFF, len=4 (carry fold 0x1FFFE) -> pass_o=1 at cycle 4.
REQ-039 len=0 -> ready_o at cycle 2, pass_o=0.
REQ-040 start_i toggled during SUM -> no restart; after DONE with start_i=0 then 1, ready_o clears and a new check runs.
REQ-041 rst=0 pulsed mid-SUM between clock edges -> outputs 0 immediately; state FREE; err_cnt_o unchanged at 0.
